tri_draw_arbiter: RTL and testbench

TRI_DRAW_ARBITER -- requirements
Module: tri_draw_arbiter

---
 rtl/tri_draw_arbiter.sv | 163 ++++++++++++++++
 tb/tb_tri_draw_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_draw_arbiter.sv
// rtl/tri_draw_arbiter.sv - round-robin arbiter feeding four requesters' triangle jobs to one draw engine.
// Optional watchdog abort compiled in with TRI_ARB_WATCHDOG_EN.
module tri_draw_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [191:0] req_vtx,
    input  logic [95:0]  req_color,
    input  logic [3:0]   req_fill,
    output logic [3:0]   ack,
    output logic [3:0]   err,
    output logic [1:0]   grant_id,
    output logic         busy,
    output logic         eng_start,
    output logic [47:0]  eng_vtx,
    output logic [23:0]  eng_color,
    output logic         eng_fill,
    input  logic         eng_done,
    output logic         eng_rst
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] pick;

    // First requesting index after last_grant, wrapping; offset 4 maps back to last_grant itself.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign pick = rr_pick(last_grant, req);

`ifdef TRI_ARB_WATCHDOG_EN
    logic [15:0] wd_count;
    logic        wd_rst;

    assign eng_rst = ~rst_n | wd_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 2'd3;
            ack        <= '0;
            err        <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            eng_vtx    <= '0;
            eng_color  <= '0;
            eng_fill   <= 1'b0;
            wd_count   <= '0;
            wd_rst     <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            ack       <= '0;
            err       <= '0;
            wd_rst    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant_id  <= pick;
                        eng_vtx   <= req_vtx[pick*48 +: 48];
                        eng_color <= req_color[pick*24 +: 24];
                        eng_fill  <= req_fill[pick];
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_count <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving in the limit cycle still completes the job normally.
                    if (eng_done) begin
                        ack   <= 4'b0001 << grant_id;
                        state <= S_DONE;
                    end else if (wd_count == TIMEOUT_CYCLES - 16'd1) begin
                        err        <= 4'b0001 << grant_id;
                        wd_rst     <= 1'b1;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        wd_count <= wd_count + 16'd1;
                    end
                end
                default: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err            = '0;
    assign eng_rst        = ~rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 2'd3;
            ack        <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            eng_vtx    <= '0;
            eng_color  <= '0;
            eng_fill   <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            ack       <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant_id  <= pick;
                        eng_vtx   <= req_vtx[pick*48 +: 48];
                        eng_color <= req_color[pick*24 +: 24];
                        eng_fill  <= req_fill[pick];
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        ack   <= 4'b0001 << grant_id;
                        state <= S_DONE;
                    end
                end
                default: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_tri_draw_arbiter.sv
// tb/tb_tri_draw_arbiter.sv - self-checking bench for tri_draw_arbiter: vector table, hand sequences, random jobs vs model.
module tb_tri_draw_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [191:0] req_vtx;
    logic [95:0]  req_color;
    logic [3:0]   req_fill;
    logic [3:0]   ack;
    logic [3:0]   err;
    logic [1:0]   grant_id;
    logic         busy;
    logic         eng_start;
    logic [47:0]  eng_vtx;
    logic [23:0]  eng_color;
    logic         eng_fill;
    logic         eng_done;
    logic         eng_rst;

    tri_draw_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_vtx   (req_vtx),
        .req_color (req_color),
        .req_fill  (req_fill),
        .ack       (ack),
        .err       (err),
        .grant_id  (grant_id),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_vtx   (eng_vtx),
        .eng_color (eng_color),
        .eng_fill  (eng_fill),
        .eng_done  (eng_done),
        .eng_rst   (eng_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        int          delay;
        logic [1:0]  g;
        logic [47:0] v;
        logic [23:0] c;
        logic        f;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  model_last;
    logic [47:0] exp_vtx;
    logic [23:0] exp_color;
    logic        exp_fill;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [1:0] model_pick(input logic [1:0] last, input logic [3:0] r);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (int'(last) + k) % 4;
            if (r[idx]) return 2'(idx);
        end
        return last;
    endfunction

    task automatic randomize_inputs();
        req_vtx   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_color = {$urandom, $urandom, $urandom};
        req_fill  = 4'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the first WAIT negedge.
    task automatic start_job(input logic [3:0] r, input logic [1:0] g,
                             input logic [47:0] v, input logic [23:0] c, input logic f);
        randomize_inputs();
        req_vtx[g*48 +: 48]   = v;
        req_color[g*24 +: 24] = c;
        req_fill[g]           = f;
        req       = r;
        exp_vtx   = v;
        exp_color = c;
        exp_fill  = f;
        @(negedge clk);
        chk("launch_start", eng_start, 1);
        chk("launch_grant", grant_id, g);
        chk("launch_vtx", eng_vtx, exp_vtx);
        chk("launch_color", eng_color, exp_color);
        chk("launch_fill", eng_fill, exp_fill);
        chk("launch_busy", busy, 1);
        // Inputs churn outside IDLE and a stray done during LAUNCH must be ignored.
        randomize_inputs();
        req      = 4'($urandom);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("wait_no_start", eng_start, 0);
        chk("wait_no_ack", ack, 0);
        chk("wait_busy", busy, 1);
    endtask

    task automatic finish_job(input int delay, input logic [1:0] g);
        for (int i = 0; i < delay; i++) begin
            randomize_inputs();
            @(negedge clk);
            chk("wait_vtx_stable", eng_vtx, exp_vtx);
            chk("wait_start_low", eng_start | (|ack) | (|err), 0);
        end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("done_ack", ack, 4'b0001 << g);
        chk("done_err", err, 0);
        chk("done_vtx", eng_vtx, exp_vtx);
        @(negedge clk);
        req = 4'b0000;
        chk("idle_ack_clear", ack, 0);
        chk("idle_busy", busy, 0);
        model_last = g;
    endtask

    vec_t        vt[12];
    logic [3:0]  rr;
    logic [1:0]  gg;
    logic [47:0] rv;
    logic [23:0] rc;
    int          bad;

    initial begin
        vt[0]  = '{4'b1111, 2, 2'd0, 48'h0102_0304_0506, 24'h112233, 1'b1};
        vt[1]  = '{4'b1111, 0, 2'd1, 48'hA0A1_A2A3_A4A5, 24'h445566, 1'b0};
        vt[2]  = '{4'b1111, 3, 2'd2, 48'hFFEE_DDCC_BBAA, 24'h778899, 1'b1};
        vt[3]  = '{4'b1111, 1, 2'd3, 48'h1234_5678_9ABC, 24'hAABBCC, 1'b0};
        vt[4]  = '{4'b1111, 0, 2'd0, 48'hCAFE_F00D_BEEF, 24'hDDEEFF, 1'b1};
        vt[5]  = '{4'b0100, 4, 2'd2, {8'd10, 8'd10, 8'd50, 8'd10, 8'd30, 8'd40}, 24'hFF0000, 1'b0};
        vt[6]  = '{4'b1001, 1, 2'd3, 48'h0000_0000_0001, 24'h000001, 1'b1};
        vt[7]  = '{4'b1001, 1, 2'd0, 48'h8000_0000_0000, 24'h800000, 1'b0};
        vt[8]  = '{4'b0011, 2, 2'd1, 48'h5555_AAAA_5555, 24'h5A5A5A, 1'b1};
        vt[9]  = '{4'b0011, 0, 2'd0, 48'hAAAA_5555_AAAA, 24'hA5A5A5, 1'b0};
        vt[10] = '{4'b1000, 5, 2'd3, 48'h0F0F_0F0F_0F0F, 24'h0F0F0F, 1'b1};
        vt[11] = '{4'b0001, 0, 2'd0, 48'hF0F0_F0F0_F0F0, 24'hF0F0F0, 1'b0};

        rst_n     = 1'b0;
        req       = '0;
        req_vtx   = '0;
        req_color = '0;
        req_fill  = '0;
        eng_done  = 1'b0;
        #12;
        chk("rst_eng_rst", eng_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack_err", {ack, err}, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_eng_outs", {eng_start, eng_vtx, eng_color, eng_fill}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_eng_rst", eng_rst, 0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            start_job(vt[i].r, vt[i].g, vt[i].v, vt[i].c, vt[i].f);
            finish_job(vt[i].delay, vt[i].g);
        end
        model_last = 2'd0;

        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("idle_done_ignored", {busy, ack, eng_start}, 0);

        gg = model_pick(model_last, 4'b0110);
        start_job(4'b0110, gg, 48'h1111_2222_3333, 24'h444444, 1'b1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("midrst_eng_rst", eng_rst, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack_err", {ack, err}, 0);
        chk("midrst_outs", {grant_id, eng_start, eng_vtx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release", eng_rst, 0);
        @(negedge clk);
        start_job(4'b1111, 2'd0, 48'h9999_8888_7777, 24'h666666, 1'b0);
        finish_job(1, 2'd0);

`ifdef TRI_ARB_WATCHDOG_EN
        gg = model_pick(model_last, 4'b1111);
        start_job(4'b1111, gg, 48'h0A0B_0C0D_0E0F, 24'h010203, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("wd_no_err_early", {err, eng_rst}, 0);
            @(negedge clk);
        end
        chk("wd_busy_limit", busy, 1);
        @(negedge clk);
        req = '0;
        chk("wd_err_pulse", err, 4'b0001 << gg);
        chk("wd_eng_rst_pulse", eng_rst, 1);
        chk("wd_no_ack", ack, 0);
        chk("wd_idle", busy, 0);
        @(negedge clk);
        chk("wd_pulse_end", {err, eng_rst}, 0);
        model_last = gg;

        gg = model_pick(model_last, 4'b1111);
        start_job(4'b1111, gg, 48'h1020_3040_5060, 24'h070809, 1'b0);
        for (int i = 0; i < 7; i++) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        req = '0;
        chk("wd_limit_ack", ack, 4'b0001 << gg);
        chk("wd_limit_no_err", {err, eng_rst}, 0);
        @(negedge clk);
        model_last = gg;
`else
        gg  = model_pick(model_last, 4'b0010);
        start_job(4'b0010, gg, 48'h7766_5544_3322, 24'h123456, 1'b1);
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || err !== 4'b0 || eng_rst !== 1'b0 || ack !== 4'b0) bad++;
        end
        chk("hold_10000_cycles", bad, 0);
        finish_job(0, gg);
`endif

        for (int n = 0; n < 40; n++) begin
            rr = 4'($urandom_range(1, 15));
            gg = model_pick(model_last, rr);
            rv = {16'($urandom), 32'($urandom)};
            rc = 24'($urandom);
            start_job(rr, gg, rv, rc, 1'($urandom));
            finish_job($urandom_range(0, 5), gg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
